// File: rtl/rv_instr_encoder.sv
// Packs symbolic RV32I operations into 32-bit instruction words behind a 2-entry output buffer.
// Define RV_ENC_IMM_CHECK_EN to make out-of-range immediates illegal instead of truncating them.
module rv_instr_encoder #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } op_e;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

    buf_state_e  state, state_next;
    logic [31:0] head_instr, head_pc, tail_instr, tail_pc, next_pc;
    logic [31:0] enc_word;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_shift_imm, op_bad, imm_bad, illegal;
    logic        accept, push, pop;

    // in_ready depends only on the registered buffer state, never on out_ready.
    assign in_ready     = (state != TWO);
    assign out_valid    = (state != EMPTY);
    assign out_instr    = head_instr;
    assign out_pc       = head_pc;
    assign accept       = in_valid && in_ready;
    assign illegal      = op_bad || imm_bad;
    assign push         = accept && !illegal;
    assign pop          = out_valid && out_ready;
    assign is_shift_imm = (in_op == OP_SLLI) || (in_op == OP_SRLI) || (in_op == OP_SRAI);
    assign funct7       = (in_op == OP_SUB || in_op == OP_SRA || in_op == OP_SRAI) ? 7'b0100000 : 7'b0000000;

    always_comb begin
        funct3 = 3'b000;
        case (in_op)
            OP_SLL, OP_SLLI, OP_LH, OP_SH, OP_BNE:               funct3 = 3'b001;
            OP_SLT, OP_SLTI, OP_LW, OP_SW:                       funct3 = 3'b010;
            OP_SLTU, OP_SLTIU:                                   funct3 = 3'b011;
            OP_XOR, OP_XORI, OP_LBU, OP_BLT:                     funct3 = 3'b100;
            OP_SRL, OP_SRA, OP_SRLI, OP_SRAI, OP_LHU, OP_BGE:    funct3 = 3'b101;
            OP_OR, OP_ORI, OP_BLTU:                              funct3 = 3'b110;
            OP_AND, OP_ANDI, OP_BGEU:                            funct3 = 3'b111;
            default:                                             funct3 = 3'b000;
        endcase
    end

    // Op numbering groups each instruction format into a contiguous range.
    always_comb begin
        enc_word = 32'h0;
        op_bad   = 1'b0;
        if (in_op <= OP_SLTU)
            enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
        else if (is_shift_imm)
            enc_word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, 7'b0010011};
        else if (in_op <= OP_SLTIU)
            enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, 7'b0010011};
        else if (in_op <= OP_LHU)
            enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, 7'b0000011};
        else if (in_op <= OP_SW)
            enc_word = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], 7'b0100011};
        else if (in_op <= OP_BGEU)
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
        else begin
            case (in_op)
                OP_JAL:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                      in_rd, 7'b1101111};
                OP_JALR:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
                OP_LUI:   enc_word = {in_imm[31:12], in_rd, 7'b0110111};
                OP_AUIPC: enc_word = {in_imm[31:12], in_rd, 7'b0010111};
                default:  op_bad   = 1'b1;
            endcase
        end
    end

`ifdef RV_ENC_IMM_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = in_imm;

    always_comb begin
        imm_bad = 1'b0;
        if (in_op <= OP_SLTU)
            imm_bad = 1'b0;
        else if (is_shift_imm)
            imm_bad = (in_imm > 32'd31);
        else if (in_op <= OP_SW || in_op == OP_JALR)
            imm_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        else if (in_op <= OP_BGEU)
            imm_bad = in_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
        else if (in_op == OP_JAL)
            imm_bad = in_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
        else if (in_op == OP_LUI || in_op == OP_AUIPC)
            imm_bad = (in_imm[11:0] != 12'h000);
    end
`else
    assign imm_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = TWO;
                else if (!push && pop) state_next = EMPTY;
            end
            TWO:     if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // A push into ONE with a simultaneous pop replaces the head directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_instr <= 32'h0;
            head_pc    <= 32'h0;
            tail_instr <= 32'h0;
            tail_pc    <= 32'h0;
            next_pc    <= PC_RESET;
            err        <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            err <= accept && illegal;
            if (accept && illegal && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (push)
                next_pc <= next_pc + PC_STEP;
            case (state)
                EMPTY: if (push) begin
                    head_instr <= enc_word;
                    head_pc    <= next_pc;
                end
                ONE: begin
                    if (push && pop) begin
                        head_instr <= enc_word;
                        head_pc    <= next_pc;
                    end else if (push) begin
                        tail_instr <= enc_word;
                        tail_pc    <= next_pc;
                    end
                end
                TWO: if (pop) begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: directed vector table, handshake corner sequences
// and randomized traffic against a table-driven reference model with an expected-output queue.
module tb_rv_instr_encoder;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_ready, out_valid, err;
    logic [31:0] out_instr, out_pc;
    logic [7:0]  err_cnt;

    rv_instr_encoder #(.PC_RESET(PC_RESET), .PC_STEP(PC_STEP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .err(err), .err_cnt(err_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] instr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    // Format letter per op: R, I(ALU), L(oad), S(tore), B(ranch), J(AL), j(JALR), U(LUI), A(UIPC)
    string fmt_tbl = {"RRRRRRRRRR", "IIIIIIIII", "LLLLL", "SSS", "BBBBBB", "JjUA"};
    int    f3_tbl [37] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3,
                           0, 4, 6, 7, 1, 5, 5, 2, 3,
                           0, 1, 2, 4, 5,
                           0, 1, 2,
                           0, 1, 4, 5, 6, 7,
                           0, 0, 0, 0};

    exp_t        exp_q[$];
    logic [31:0] m_pc = PC_RESET;
    int          m_err_cnt = 0;
    bit          exp_err = 1'b0;
    bit          last_acc = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    vec_t        vecs[14];

    function automatic logic [31:0] refEncode(int op, logic [31:0] rd, logic [31:0] rs1,
                                              logic [31:0] rs2, logic [31:0] imm);
        logic [31:0] w, f3, alt;
        byte         f;
        f   = fmt_tbl[op];
        f3  = f3_tbl[op];
        alt = (op == 1 || op == 7 || op == 16) ? (32'h1 << 30) : 32'h0;
        case (f)
            "R": w = alt | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            "I": if (f3 == 1 || f3 == 5)
                     w = alt | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                 else
                     w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            "L": w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
            "S": w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                     | ((imm & 32'h1F) << 7) | 32'h23;
            "B": w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                     | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                     | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            "J": w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                     | (rd << 7) | 32'h6F;
            "j": w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            "U": w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
            default: w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
        endcase
        return w;
    endfunction

    function automatic bit refLegal(int op, logic [31:0] imm);
`ifdef RV_ENC_IMM_CHECK_EN
        int  s;
        byte f;
`endif
        if (op > 36) return 1'b0;
`ifdef RV_ENC_IMM_CHECK_EN
        s = imm;
        f = fmt_tbl[op];
        if (f == "I" && (f3_tbl[op] == 1 || f3_tbl[op] == 5)) return (s >= 0 && s <= 31);
        if (f == "I" || f == "L" || f == "S" || f == "j") return (s >= -2048 && s <= 2047);
        if (f == "B") return (s % 2 == 0) && (s >= -4096) && (s <= 4094);
        if (f == "J") return (s % 2 == 0) && (s >= -(1 << 20)) && (s <= (1 << 20) - 2);
        if (f == "U" || f == "A") return (s % 4096 == 0);
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(bit v, int op, int rd, int rs1, int rs2, logic [31:0] imm);
        in_valid = v;
        in_op    = 6'(op);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = imm;
    endtask

    // One clock: update the model from the inputs as presented, then check the DUT after the edge.
    task automatic tick();
        bit   acc, pop;
        exp_t e;
        acc = in_valid && (exp_q.size() < 2) && !reset;
        pop = out_ready && (exp_q.size() > 0) && !reset;
        if (pop) begin
            e = exp_q.pop_front();
            checkOutput("pop_instr", out_instr, e.instr);
            checkOutput("pop_pc", out_pc, e.pc);
        end
        exp_err = 1'b0;
        if (acc) begin
            if (!refLegal(int'(in_op), in_imm)) begin
                exp_err = 1'b1;
                if (m_err_cnt < 255) m_err_cnt++;
            end else begin
                e.instr = refEncode(int'(in_op), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm);
                e.pc    = m_pc;
                exp_q.push_back(e);
                m_pc = m_pc + PC_STEP;
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            m_pc      = PC_RESET;
            m_err_cnt = 0;
            exp_err   = 1'b0;
        end
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    endtask

    task automatic sendReq(int op, int rd, int rs1, int rs2, logic [31:0] imm);
        bit done = 1'b0;
        applyStimulus(1'b1, op, rd, rs1, rs2, imm);
        for (int t = 0; t < 10 && !done; t++) begin
            tick();
            done = last_acc;
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("rst_instr", out_instr, 32'h0);
        checkOutput("rst_pc", out_pc, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{6'd0,  5'd3,  5'd1,  5'd2,  32'd0,          32'h002081B3}; // ADD
        vecs[1]  = '{6'd1,  5'd3,  5'd1,  5'd2,  32'd0,          32'h402081B3}; // SUB
        vecs[2]  = '{6'd10, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF,   32'hFFF00093}; // ADDI -1
        vecs[3]  = '{6'd26, 5'd0,  5'd1,  5'd2,  32'd8,          32'h0020A423}; // SW
        vecs[4]  = '{6'd27, 5'd0,  5'd1,  5'd2,  32'd8,          32'h00208463}; // BEQ
        vecs[5]  = '{6'd35, 5'd5,  5'd0,  5'd0,  32'h12345000,   32'h123452B7}; // LUI
        vecs[6]  = '{6'd16, 5'd1,  5'd2,  5'd0,  32'd3,          32'h40315093}; // SRAI
        vecs[7]  = '{6'd33, 5'd1,  5'd0,  5'd0,  32'd8,          32'h008000EF}; // JAL
        vecs[8]  = '{6'd21, 5'd5,  5'd2,  5'd0,  32'd4,          32'h00412283}; // LW
        vecs[9]  = '{6'd34, 5'd0,  5'd1,  5'd0,  32'd0,          32'h00008067}; // JALR
        vecs[10] = '{6'd36, 5'd1,  5'd0,  5'd0,  32'h00001000,   32'h00001097}; // AUIPC
        vecs[11] = '{6'd28, 5'd0,  5'd5,  5'd0,  32'hFFFFFFFC,   32'hFE029EE3}; // BNE -4
        vecs[12] = '{6'd9,  5'd10, 5'd11, 5'd12, 32'd0,          32'h00C5B533}; // SLTU
        vecs[13] = '{6'd24, 5'd0,  5'd2,  5'd5,  32'hFFFFFFFF,   32'hFE510FA3}; // SB -1

        doReset();

        for (int i = 0; i < 14; i++) begin
            out_ready = 1'b0;
            sendReq(int'(vecs[i].op), int'(vecs[i].rd), int'(vecs[i].rs1), int'(vecs[i].rs2), vecs[i].imm);
            checkOutput($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
            checkOutput($sformatf("vec%0d_pc", i), out_pc, PC_RESET + 32'(i) * PC_STEP);
            out_ready = 1'b1;
            tick();
        end

        // Illegal op: consumed, flagged, PC not advanced
        doReset();
        out_ready = 1'b0;
        sendReq(40, 1, 1, 1, 32'd0);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_cnt", 32'(err_cnt), 32'd1);
        checkOutput("illegal_none", 32'(out_valid), 32'd0);
        sendReq(0, 3, 1, 2, 32'd0);
        checkOutput("after_illegal_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`ifdef RV_ENC_IMM_CHECK_EN
        sendReq(10, 1, 0, 0, 32'd4096);
        sendReq(27, 0, 1, 2, 32'd3);
        checkOutput("imm_chk_cnt", 32'(err_cnt), 32'd3);
`else
        sendReq(10, 1, 0, 0, 32'd4096);
        checkOutput("imm_trunc_instr", out_instr, 32'h00000093);
        checkOutput("imm_trunc_pc", out_pc, 32'h4);
`endif
        out_ready = 1'b1;
        tick();
        tick();

        // Backpressure: two fill the buffer, third waits until a slot frees
        doReset();
        out_ready = 1'b0;
        sendReq(0, 3, 1, 2, 32'd0);
        sendReq(1, 3, 1, 2, 32'd0);
        checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 2, 3, 1, 2, 32'd0);
        tick();
        tick();
        checkOutput("bp_hold_instr", out_instr, 32'h002081B3);
        checkOutput("bp_hold_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_second_pc", out_pc, 32'h4);
        tick();
        checkOutput("bp_third_accepted", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        checkOutput("bp_third_instr", out_instr, 32'h0020C1B3);
        checkOutput("bp_third_pc", out_pc, 32'h8);
        tick();

        // Reset while full and stalled, with a request still offered
        out_ready = 1'b0;
        sendReq(45, 0, 0, 0, 32'd0);
        sendReq(0, 3, 1, 2, 32'd0);
        sendReq(0, 4, 1, 2, 32'd0);
        applyStimulus(1'b1, 0, 5, 1, 2, 32'd0);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_cnt", 32'(err_cnt), 32'd0);
        sendReq(0, 3, 1, 2, 32'd0);
        checkOutput("midrst_pc", out_pc, PC_RESET);
        out_ready = 1'b1;
        tick();

        // Error counter saturation
        applyStimulus(1'b1, 50, 0, 0, 0, 32'd0);
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        checkOutput("sat_cnt", 32'(err_cnt), 32'd255);
        tick();

        // Randomized traffic against the reference model
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 3))
                0:       imm = $urandom_range(0, 63);
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       imm = $urandom() & 32'hFFFFF000;
                default: imm = $urandom();
            endcase
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 40), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 31), imm);
            out_ready = $urandom_range(0, 9) < 6;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder. Accepts a symbolic RV32I operation (op code, register indices, immediate) and packs it into a legal 32-bit RV32I instruction word.
- Output is registered behind a 2-entry buffer with valid/ready handshakes on both sides.
- Tracks the PC of each emitted word.
- Used by test-program generators and the self-test sequencer to feed instruction memory or the fetch stage.

Parameters:
- PC_RESET, 32'h0000_0000, PC tagged on the first emitted instruction.
- PC_STEP, 4, PC increment per emitted instruction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept this cycle.
- in_op  in  6  op select, numbered 0..36 in this order:
  - ADD SUB XOR OR AND SLL SRL SRA SLT SLTU
  - ADDI XORI ORI ANDI SLLI SRLI SRAI SLTI SLTIU
  - LB LH LW LBU LHU
  - SB SH SW
  - BEQ BNE BLT BGE BLTU BGEU
  - JAL JALR LUI AUIPC
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused fields are ignored and encoded as their raw bits.
- in_imm  in  32  signed immediate (byte offset for B/J); for LUI/AUIPC only in_imm[31:12] is used.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_pc  out  32  PC tag of out_instr.
- err  out  1  one-cycle pulse: the request accepted in the previous cycle was illegal.
- err_cnt  out  8  count of illegal requests, saturates at 255.

Behaviour:
- Opcode values:
  - R-type 0110011; I-ALU 0010011; load 0000011; store 0100011; branch 1100011.
  - JAL 1101111; JALR 1100111; LUI 0110111; AUIPC 0010111.
- funct3 and funct7 follow the RV32I spec.
- SUB and SRA set funct7=0100000; SRAI sets instr[30]=1.
- Shift-immediates place in_imm[4:0] in instr[24:20], with instr[31:25] as above.
- Immediate packing:
  - I: imm[11:0] -> [31:20].
  - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B: imm[12|10:5] -> [31|30:25], imm[4:1|11] -> [11:8|7].
  - J: imm[20|10:1|11|19:12] -> [31|30:21|20|19:12].
  - U: imm[31:12] -> [31:12].
- Handshake:
  - Transfer on in_valid&&in_ready, and separately on out_valid&&out_ready.
  - in_ready = (occupancy<2); it is registered-only state, with no combinational path from out_ready.
- Pipeline and buffering:
  - One-stage pipeline: an accepted legal request appears at the buffer head no earlier than the next cycle.
  - Minimum latency is 1 cycle.
  - Buffer states: EMPTY, ONE, TWO.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Push in TWO cannot occur, because in_ready=0.
  - Pop in EMPTY cannot occur, because out_valid=0.
  - FIFO order is preserved.
  - While out_valid=1 and out_ready=0, out_instr and out_pc are held stable.
- PC:
  - An internal next_pc register starts at PC_RESET.
  - Each legal push tags the entry with next_pc, then next_pc += PC_STEP, wrapping modulo 2^32.
  - Illegal requests do not advance the PC.
- Illegal requests:
  - Condition: in_op>36, or an immediate range violation (see Optional Feature).
  - The request is still consumed (in_ready as normal) but is not pushed.
  - err pulses the cycle after acceptance.
  - err_cnt increments, holding at 255.
- Reset:
  - Applies on any cycle, including mid-transfer.
  - Buffer is emptied: out_valid=0, out_instr=0, out_pc=0.
  - in_ready=1 from the first cycle after reset, next_pc=PC_RESET, err=0, err_cnt=0.
  - Any in-flight request is discarded.

Optional Feature:
- Macro: RV_ENC_IMM_CHECK_EN.
- Defined: immediates are range-checked, and any violation makes the request illegal. Ranges:
  - I/load/store/JALR: [-2048, 2047].
  - Shift-immediate: in_imm in [0, 31].
  - B: even, [-4096, 4094].
  - J: even, [-2^20, 2^20-2].
  - LUI/AUIPC: in_imm[11:0]==0.
- Undefined: no checks; out-of-range immediates are silently truncated to the encoded bits. Only in_op>36 is illegal.

Test Plan:
- ADD rd=3 rs1=1 rs2=2, out_ready=1 -> out_instr=0x002081B3, out_pc=0x0 one cycle later. Then SUB with the same fields -> 0x402081B3, out_pc=0x4.
- ADDI rd=1 rs1=0 imm=-1 -> 0xFFF00093. SW rs1=1 rs2=2 imm=8 -> 0x0020A423. BEQ rs1=1 rs2=2 imm=8 -> 0x00208463. LUI rd=5 imm=0x12345000 -> 0x123452B7.
- Backpressure: out_ready=0, push 3 requests -> in_ready drops after the 2nd accept. Outputs are held stable. Raising out_ready drains them in order with PCs 0x0 and 0x4, then the 3rd is accepted with PC 0x8.
- in_op=40 -> err pulses once, err_cnt=1, nothing emitted, next legal word keeps the un-advanced PC. With RV_ENC_IMM_CHECK_EN: ADDI imm=4096 and BEQ imm=3 -> both illegal, err_cnt=3.
- 300 illegal requests -> err_cnt saturates at 255.
- Reset asserted while in TWO with out_ready=0 -> next cycle out_valid=0, in_ready=1, err_cnt=0; next emitted out_pc=PC_RESET.
